// File: rtl/control_sequencer_if.sv
// Handshake bundle between the instruction register / decoder and the control sequencer.
// The master side is the sequencer: it consumes run/instr and drives the state-code outputs.
interface control_sequencer_if #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
);
  logic            run;
  logic [15:0]     instr;
  logic [7:0]      state;
  logic [OPW-1:0]  opcode;
  logic            instr_done;
  logic            halted;
  logic [CNTW-1:0] retired;

  modport master (
    input  run,
    input  instr,
    output state,
    output opcode,
    output instr_done,
    output halted,
    output retired
  );

  modport slave (
    output run,
    output instr,
    input  state,
    input  opcode,
    input  instr_done,
    input  halted,
    input  retired
  );
endinterface

// File: rtl/control_sequencer.sv
// Control-path state generator: fetch, opcode latch and per-instruction execute codes for the decoder.
// All outputs come straight from flops; instr/run only influence the next state.
module control_sequencer #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic                clock,
  input  logic                resetn,
  control_sequencer_if.master bus
);

  typedef enum logic [7:0] {
    S_IDLE   = 8'h00, S_FETCH  = 8'h0F, S_DECODE = 8'h01,
    S_LOAD   = 8'h02, S_MOVE   = 8'h03, S_LDPC   = 8'h04, S_BRANCH = 8'h05,
    S_SUB0   = 8'h06, S_SUB1   = 8'h07, S_SUB2   = 8'h08,
    S_ADD0   = 8'h09, S_ADD1   = 8'h0A, S_ADD2   = 8'h0B,
    S_XOR0   = 8'h0C, S_XOR1   = 8'h0D, S_XOR2   = 8'h0E,
    S_PUSH0  = 8'h13, S_PUSH1  = 8'h14, S_PUSH2  = 8'h15, S_PUSH3  = 8'h16,
    S_POP0   = 8'h17, S_POP1   = 8'h18, S_POP2   = 8'h19, S_POP3   = 8'h1A,
    S_CALL0  = 8'h1B, S_CALL1  = 8'h1C, S_CALL2  = 8'h1D, S_CALL3  = 8'h1E,
    S_CALL4  = 8'h1F, S_CALL5  = 8'h20, S_CALL6  = 8'h25,
    S_RET0   = 8'h21, S_RET1   = 8'h22, S_RET2   = 8'h23, S_RET3   = 8'h24,
    S_HALT   = 8'h3F
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [OPW-1:0]  opcode_r;
  logic            done_r;
  logic            done_s;
  logic            halted_r;
  logic [CNTW-1:0] retired_r;
  logic [3:0]      op_s;
  logic            unused_instr_s;

  assign op_s           = bus.instr[15:12];
  assign unused_instr_s = ^bus.instr[11:0];

  // Final execute code of every retiring instruction.
  function automatic logic is_last(input state_t s);
    case (s)
      S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_SUB2, S_ADD2, S_XOR2,
      S_PUSH3, S_POP3, S_CALL6, S_RET3: is_last = 1'b1;
      default:                          is_last = 1'b0;
    endcase
  endfunction

  // Next-state selection; execute chains are unique so only the decode step looks at the opcode.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE:   next_state_s = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (op_s)
          4'd0:    next_state_s = S_LOAD;
          4'd1:    next_state_s = S_MOVE;
          4'd2:    next_state_s = S_LDPC;
          4'd3:    next_state_s = S_BRANCH;
          4'd4:    next_state_s = S_SUB0;
          4'd5:    next_state_s = S_ADD0;
          4'd6:    next_state_s = S_XOR0;
          4'd7:    next_state_s = S_PUSH0;
          4'd8:    next_state_s = S_POP0;
          4'd9:    next_state_s = S_CALL0;
          4'd10:   next_state_s = S_RET0;
          4'd15:   next_state_s = S_HALT;
          default: next_state_s = S_IDLE;
        endcase
      end
      S_SUB0:   next_state_s = S_SUB1;
      S_SUB1:   next_state_s = S_SUB2;
      S_ADD0:   next_state_s = S_ADD1;
      S_ADD1:   next_state_s = S_ADD2;
      S_XOR0:   next_state_s = S_XOR1;
      S_XOR1:   next_state_s = S_XOR2;
      S_PUSH0:  next_state_s = S_PUSH1;
      S_PUSH1:  next_state_s = S_PUSH2;
      S_PUSH2:  next_state_s = S_PUSH3;
      S_POP0:   next_state_s = S_POP1;
      S_POP1:   next_state_s = S_POP2;
      S_POP2:   next_state_s = S_POP3;
      S_CALL0:  next_state_s = S_CALL1;
      S_CALL1:  next_state_s = S_CALL2;
      S_CALL2:  next_state_s = S_CALL3;
      S_CALL3:  next_state_s = S_CALL4;
      S_CALL4:  next_state_s = S_CALL5;
      S_CALL5:  next_state_s = S_CALL6;
      S_RET0:   next_state_s = S_RET1;
      S_RET1:   next_state_s = S_RET2;
      S_RET2:   next_state_s = S_RET3;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_IDLE;
    endcase
    done_s = is_last(next_state_s);
  end

  // State register plus flags derived from the next state so they line up with the state code.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      opcode_r  <= {OPW{1'b0}};
      done_r    <= 1'b0;
      halted_r  <= 1'b0;
      retired_r <= {CNTW{1'b0}};
    end else begin
      state_r  <= next_state_s;
      done_r   <= done_s;
      halted_r <= (next_state_s == S_HALT);
      // Only the decode exit loads the opcode; the call's IR reload at 0x1D is ignored.
      if (state_r == S_DECODE) begin
        opcode_r <= OPW'(op_s);
      end else begin
        opcode_r <= opcode_r;
      end
      if (done_r) begin
        retired_r <= retired_r + CNTW'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign bus.state      = state_r;
  assign bus.opcode     = opcode_r;
  assign bus.instr_done = done_r;
  assign bus.halted     = halted_r;
  assign bus.retired    = retired_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-written state-code lists checked cycle by cycle.
module tb_control_sequencer;

  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;
  logic [3:0] exp_ret;

  control_sequencer_if #(.OPW(4), .CNTW(4)) bus ();

  control_sequencer #(.OPW(4), .CNTW(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from state 0x00; exe lists the execute codes left-aligned.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] ins2,
                           input int ne, input logic [55:0] exe);
    logic [7:0] code;
    logic [7:0] last;
    last = (ne > 0) ? exe[55-8*(ne-1) -: 8] : 8'hFF;
    bus.instr = ins;
    for (int i = 0; i < ne + 3; i++) begin
      if (i == 0)      code = 8'h00;
      else if (i == 1) code = 8'h0F;
      else if (i == 2) code = 8'h01;
      else             code = exe[55-8*(i-3) -: 8];
      chk("state", 16'(bus.state), 16'(code));
      chk("instr_done", 16'(bus.instr_done), 16'(code == last));
      chk("halted", 16'(bus.halted), 16'h0);
      if (code == 8'h1D) bus.instr = ins2;
      tick();
    end
    if (ne > 0) exp_ret = exp_ret + 4'd1;
    chk("end_state", 16'(bus.state), 16'h0000);
    chk("opcode", 16'(bus.opcode), 16'(ins[15:12]));
    chk("retired", 16'(bus.retired), 16'(exp_ret));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_ret     = 4'd0;
    resetn      = 1'b0;
    bus.run     = 1'b0;
    bus.instr   = 16'h0000;
    #12;
    chk("rst_state", 16'(bus.state), 16'h0000);
    chk("rst_opcode", 16'(bus.opcode), 16'h0000);
    chk("rst_done", 16'(bus.instr_done), 16'h0000);
    chk("rst_halted", 16'(bus.halted), 16'h0000);
    chk("rst_retired", 16'(bus.retired), 16'h0000);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold", 16'(bus.state), 16'h0000);
    end

    bus.run = 1'b1;
    run_instr(16'h0120, 16'h0120, 1, {8'h02, 48'h0});
    run_instr(16'h5340, 16'h5340, 3, {8'h09, 8'h0A, 8'h0B, 32'h0});
    chk("retired_two", 16'(bus.retired), 16'h0002);

    // Abort an add at 0x0A with an asynchronous reset.
    bus.instr = 16'h5000;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_add", 16'(bus.state), 16'h000A);
    resetn = 1'b0;
    #1;
    chk("abort_state", 16'(bus.state), 16'h0000);
    chk("abort_retired", 16'(bus.retired), 16'h0000);
    chk("abort_opcode", 16'(bus.opcode), 16'h0000);
    exp_ret = 4'd0;
    tick();
    resetn  = 1'b1;
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_after_abort", 16'(bus.state), 16'h0000);
    end
    bus.run = 1'b1;

    run_instr(16'h9000, 16'h0123, 7, {8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20, 8'h25});
    run_instr(16'h7ABC, 16'h7ABC, 4, {8'h13, 8'h14, 8'h15, 8'h16, 24'h0});
    run_instr(16'h8001, 16'h8001, 4, {8'h17, 8'h18, 8'h19, 8'h1A, 24'h0});
    run_instr(16'hA000, 16'hA000, 4, {8'h21, 8'h22, 8'h23, 8'h24, 24'h0});
    run_instr(16'h4FFF, 16'h4FFF, 3, {8'h06, 8'h07, 8'h08, 32'h0});
    run_instr(16'h6000, 16'h6000, 3, {8'h0C, 8'h0D, 8'h0E, 32'h0});
    run_instr(16'h1234, 16'h1234, 1, {8'h03, 48'h0});
    run_instr(16'h2000, 16'h2000, 1, {8'h04, 48'h0});
    run_instr(16'h3000, 16'h3000, 1, {8'h05, 48'h0});
    run_instr(16'hC000, 16'hC000, 0, 56'h0);

    // run dropped mid-instruction: the sub still completes, then parks.
    bus.instr = 16'h4000;
    tick();
    chk("park_fetch", 16'(bus.state), 16'h000F);
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("park_last", 16'(bus.state), 16'h0008);
    chk("park_done", 16'(bus.instr_done), 16'h0001);
    tick();
    exp_ret = exp_ret + 4'd1;
    chk("park_idle", 16'(bus.state), 16'h0000);
    chk("park_retired", 16'(bus.retired), 16'(exp_ret));
    tick();
    chk("park_hold", 16'(bus.state), 16'h0000);

    // Counter wrap from a fresh reset.
    resetn = 1'b0;
    tick();
    resetn  = 1'b1;
    bus.run = 1'b1;
    exp_ret = 4'd0;
    chk("wrap_start", 16'(bus.retired), 16'h0000);
    for (int k = 1; k <= 17; k++) begin
      run_instr(16'h1000, 16'h1000, 1, {8'h03, 48'h0});
      if (k == 15) chk("wrap_15", 16'(bus.retired), 16'h000F);
      if (k == 16) chk("wrap_16", 16'(bus.retired), 16'h0000);
      if (k == 17) chk("wrap_17", 16'(bus.retired), 16'h0001);
    end

    // Halt is sticky regardless of run/instr.
    bus.instr = 16'hF000;
    chk("halt_idle", 16'(bus.state), 16'h0000);
    tick();
    chk("halt_fetch", 16'(bus.state), 16'h000F);
    tick();
    chk("halt_decode", 16'(bus.state), 16'h0001);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", 16'(bus.state), 16'h003F);
      chk("halt_flag", 16'(bus.halted), 16'h0001);
      chk("halt_done", 16'(bus.instr_done), 16'h0000);
      chk("halt_retired", 16'(bus.retired), 16'(exp_ret));
      bus.run   = 1'($urandom_range(0, 1));
      bus.instr = 16'($urandom);
      tick();
    end
    resetn = 1'b0;
    #1;
    chk("unhalt_state", 16'(bus.state), 16'h0000);
    chk("unhalt_flag", 16'(bus.halted), 16'h0000);
    tick();
    resetn  = 1'b1;
    bus.run = 1'b0;
    tick();
    chk("unhalt_idle", 16'(bus.state), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
